mod_sub_seq: RTL and testbench

Sequential modular subtractor for the secp256k1 field: computes diff = (x − y) mod p, with p = 2^256 − 2^32 − 977. It is the inverse counterpart of the combinational mod_add and is used by the point-arithmetic datapath wherever field negation or subtraction is needed. It processes one limb per cycle to keep the carry chain short, and exchanges operands and results over valid/ready handshakes.

---
 rtl/secp256k1_pkg.sv | 20 ++
 rtl/limb_addsub.sv | 33 +++
 rtl/mod_sub_seq.sv | 143 ++++++++++++++
 tb/tb_mod_sub_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/secp256k1_pkg.sv
// secp256k1_pkg
// Shared definitions for the secp256k1 field-arithmetic blocks:
//   P          - field prime 2^256 - 2^32 - 977
//   LIMB_W_DEF - default limb width for the limb-serial blocks
//   state_t    - FSM encoding shared by the sequential field blocks
package secp256k1_pkg;

    localparam logic [255:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    localparam int LIMB_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/limb_addsub.sv
// limb_addsub
// Combinational single-limb adder/subtractor, W+1 bit arithmetic.
//   a, b  : limb operands
//   cin   : carry-in (add) or borrow-in (sub)
//   sub   : 1 = a - b - cin, 0 = a + b + cin
//   r     : limb result
//   cout  : carry-out (add) or borrow-out (sub)
module limb_addsub #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic [W-1:0] r,
    output logic         cout
);

    logic [W:0] ext;

    // In subtract mode the operands are zero-extended by one bit, so a
    // negative result shows up as bit W set, which is exactly the borrow.
    always_comb begin
        if (sub) begin
            ext = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
        end else begin
            ext = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        end
        r    = ext[W-1:0];
        cout = ext[W];
    end

endmodule

// File: rtl/mod_sub_seq.sv
// mod_sub_seq
// Limb-serial modular subtractor for the secp256k1 field:
//   diff = (x - y) mod p, one LIMB_W-bit limb per cycle.
// Flow: IDLE -> SUB (NLIMB cycles) -> [FIX (NLIMB cycles) if wrapped] -> DONE.
// Ports:
//   clk, reset (async, active low)
//   x, y, in_valid, in_ready    - operand handshake (x, y < p)
//   diff, out_valid, out_ready  - result handshake
//   state_dbg                   - current FSM state, for observation
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// and diff is held stable while out_valid is high and out_ready is low.
module mod_sub_seq
    import secp256k1_pkg::*;
#(
    parameter int LIMB_W = LIMB_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [255:0] x,
    input  logic [255:0] y,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [255:0] diff,
    output logic         out_valid,
    input  logic         out_ready,
    output state_t       state_dbg
);

    localparam int NLIMB = 256 / LIMB_W;
    localparam int IDX_W = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLIMB - 1);

    state_t             state;
    logic [255:0]       x_q;
    logic [255:0]       y_q;
    logic [IDX_W-1:0]   idx;
    logic               bc;       // borrow in SUB, carry in FIX

    logic [LIMB_W-1:0]  op_a;
    logic [LIMB_W-1:0]  op_b;
    logic [LIMB_W-1:0]  limb_r;
    logic               limb_c;
    logic               is_sub;
    logic               last;

    // SUB works on the latched operands; FIX adds p back onto the partial
    // result already sitting in diff, so one adder serves both phases.
    always_comb begin
        is_sub = (state == SUB);
        last   = (idx == LAST_IDX);
        if (is_sub) begin
            op_a = x_q[int'(idx)*LIMB_W +: LIMB_W];
            op_b = y_q[int'(idx)*LIMB_W +: LIMB_W];
        end else begin
            op_a = diff[int'(idx)*LIMB_W +: LIMB_W];
            op_b = P[int'(idx)*LIMB_W +: LIMB_W];
        end
    end

    limb_addsub #(
        .W (LIMB_W)
    ) u_limb (
        .a    (op_a),
        .b    (op_b),
        .cin  (bc),
        .sub  (is_sub),
        .r    (limb_r),
        .cout (limb_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            idx       <= '0;
            bc        <= 1'b0;
            diff      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_q      <= x;
                        y_q      <= y;
                        idx      <= '0;
                        bc       <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= SUB;
                    end
                end
                SUB: begin
                    diff[int'(idx)*LIMB_W +: LIMB_W] <= limb_r;
                    if (last) begin
                        idx <= '0;
                        // The add-back carry chain starts from zero.
                        bc  <= 1'b0;
                        if (limb_c) begin
                            state <= FIX;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                        bc  <= limb_c;
                    end
                end
                FIX: begin
                    diff[int'(idx)*LIMB_W +: LIMB_W] <= limb_r;
                    if (last) begin
                        // Final carry out is the 2^256 wrap; dropping it
                        // leaves the exact result.
                        idx       <= '0;
                        bc        <= 1'b0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                        bc  <= limb_c;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_mod_sub_seq.sv
// tb_mod_sub_seq
// Directed vectors with hand-computed results for mod_sub_seq, plus a
// randomised regression against a (x - y) mod p reference.
module tb_mod_sub_seq;
    import secp256k1_pkg::*;

    localparam logic [255:0] P_REF =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] PM1 =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2E;
    localparam logic [255:0] PM2 =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2D;

    logic         clk;
    logic         reset;
    logic [255:0] x;
    logic [255:0] y;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] diff;
    logic         out_valid;
    logic         out_ready;
    state_t       state_dbg;

    int n_cmp;
    int n_err;
    logic [255:0] exp_q[$];

    mod_sub_seq dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] ref_sub(input logic [255:0] a, input logic [255:0] b);
        if (a >= b) return a - b;
        return a - b + P_REF;
    endfunction

    function automatic logic [255:0] rand_fe();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        if (v >= P_REF) v = v - P_REF;
        return v;
    endfunction

    // Drives one operation from IDLE, checks latency, FIX usage, result,
    // optional backpressure window, and the output transfer.
    task automatic run_op(input string tag, input logic [255:0] a, input logic [255:0] b,
                          input logic [255:0] exp_diff, input int exp_lat, input int hold);
        int lat;
        logic saw_fix;
        logic [255:0] e;
        check({tag, ":in_ready_pre"}, 256'(in_ready), 256'(1));
        exp_q.push_back(exp_diff);
        x = a;
        y = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        saw_fix = 1'b0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (state_dbg == FIX) saw_fix = 1'b1;
        end
        e = exp_q.pop_front();
        check({tag, ":latency"}, 256'(lat), 256'(exp_lat));
        check({tag, ":fix_used"}, 256'(saw_fix), 256'(exp_lat == 16));
        check({tag, ":diff"}, diff, e);
        check({tag, ":in_ready_busy"}, 256'(in_ready), 256'(0));
        for (int k = 0; k < hold; k++) begin
            if (k == 1) begin
                x = 256'h1234;
                y = 256'h99;
                in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            check({tag, ":hold_valid"}, 256'(out_valid), 256'(1));
            check({tag, ":hold_ready"}, 256'(in_ready), 256'(0));
            check({tag, ":hold_diff"}, diff, e);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ":post_valid"}, 256'(out_valid), 256'(0));
        check({tag, ":post_ready"}, 256'(in_ready), 256'(1));
    endtask

    initial begin
        int ov_seen;
        logic [255:0] ra, rb;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        x = '0;
        y = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst:in_ready", 256'(in_ready), 256'(1));
        check("rst:out_valid", 256'(out_valid), 256'(0));
        check("rst:diff", diff, 256'(0));
        check("rst:state", 256'(state_dbg), 256'(IDLE));
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle:state", 256'(state_dbg), 256'(IDLE));

        run_op("5m3", 256'd5, 256'd3, 256'd2, 8, 0);
        run_op("3m5", 256'd3, 256'd5, PM2, 16, 0);
        run_op("pm1_pm1", PM1, PM1, 256'd0, 8, 0);
        run_op("0_pm1", 256'd0, PM1, 256'd1, 16, 0);
        run_op("pm1_0", PM1, 256'd0, PM1, 8, 0);
        run_op("bp_1m2", 256'd1, 256'd2, PM1, 16, 5);
        // the in_valid pulse during backpressure must not start an operation
        @(posedge clk); #1;
        check("bp:idle_after", 256'(state_dbg), 256'(IDLE));

        // reset during the 4th SUB cycle
        x = 256'd9;
        y = 256'd4;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("mid:in_sub", 256'(state_dbg), 256'(SUB));
        reset = 1'b0;
        #1;
        check("mid:state", 256'(state_dbg), 256'(IDLE));
        check("mid:in_ready", 256'(in_ready), 256'(1));
        check("mid:out_valid", 256'(out_valid), 256'(0));
        check("mid:diff", diff, 256'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        ov_seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) ov_seen++;
        end
        check("mid:no_out_valid", 256'(ov_seen), 256'(0));
        run_op("7m2", 256'd7, 256'd2, 256'd5, 8, 0);

        for (int i = 0; i < 1000; i++) begin
            ra = rand_fe();
            rb = rand_fe();
            if (i % 10 == 0) rb = ra;
            run_op("rnd", ra, rb, ref_sub(ra, rb), (ra < rb) ? 16 : 8, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // global time limit
    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
